// File: rtl/sobel_window_pipe.sv
// Streaming 3x3 Sobel stage: three row words in per beat, one word of clamped |Gx|+|Gy| out.
// Window align -> gradients -> magnitude/clamp -> output register, all held together under backpressure.
module sobel_window_pipe #(
  parameter int WIDTH  = 352,
  parameter int HEIGHT = 288
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] row_above,
  input  logic [31:0] row_cur,
  input  logic [31:0] row_below,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_eol,
  output logic        out_eof,
  output logic        busy
);
  // state | meaning
  // IDLE  | no frame active, beats ignored
  // RUN   | accepting beats of the current row
  // FLUSH | one-cycle internal beat that completes the last word of a row
  localparam int WPR  = WIDTH / 4;
  localparam int COLW = $clog2(WPR);
  localparam int ROWW = $clog2(HEIGHT);
  localparam logic [COLW-1:0] COL_LAST = COLW'(WPR - 1);
  localparam logic [ROWW-1:0] ROW_LAST = ROWW'(HEIGHT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;
  state_t state, state_nx;

  logic            en, accept, flush_go, emit, all_in;
  logic [COLW-1:0] col, cur_col;
  logic [ROWW-1:0] row, cur_row;
  logic [31:0]     cur_a, cur_b, cur_c;
  logic [7:0]      prv_a, prv_b, prv_c, nxt_a, nxt_b, nxt_c;
  logic [3:0]      keep_w;

  logic               v1, eol1, eof1;
  logic [47:0]        win_a, win_b, win_c;
  logic [3:0]         keep1;
  logic               v2, eol2, eof2;
  logic [3:0]         keep2;
  logic signed [10:0] gx_c [4];
  logic signed [10:0] gy_c [4];
  logic signed [10:0] gx2 [4];
  logic signed [10:0] gy2 [4];
  logic               v3, eol3, eof3;
  logic [31:0]        pix3, pix_c;
  logic [11:0]        mag_c [4];

  function automatic logic signed [10:0] px1(input logic [7:0] p);
    return $signed({3'b000, p});
  endfunction

  function automatic logic signed [10:0] px2(input logic [7:0] p);
    return $signed({2'b00, p, 1'b0});
  endfunction

  function automatic logic [10:0] abs11(input logic signed [10:0] v);
    return v[10] ? -v : v;
  endfunction

  // The whole pipe moves as one; a stalled output freezes every stage.
  assign en       = ~(out_valid & ~out_ready);
  assign accept   = in_valid & in_ready;
  assign flush_go = (state == FLUSH) & en & ~frame_start;
  assign emit     = (accept & (col != '0)) | flush_go;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (frame_start) state_nx = RUN;
    else begin
      case (state)
        RUN: begin
          if (accept && col == COL_LAST)                state_nx = FLUSH;
          else if (out_valid && out_ready && out_eof)   state_nx = IDLE;
        end
        FLUSH:   if (en) state_nx = RUN;
        default: state_nx = state;
      endcase
    end
  end

  always_comb begin
    in_ready = (state == RUN) & ~all_in & en & ~frame_start;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0; row <= '0; all_in <= 1'b0;
      cur_a <= '0; cur_b <= '0; cur_c <= '0;
      prv_a <= '0; prv_b <= '0; prv_c <= '0;
      cur_col <= '0; cur_row <= '0;
    end else if (frame_start) begin
      col <= '0; row <= '0; all_in <= 1'b0;
    end else if (accept) begin
      if (col == COL_LAST) begin
        col <= '0;
        if (row == ROW_LAST) all_in <= 1'b1;
        else                 row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
      prv_a <= (col == '0) ? 8'h00 : cur_a[31:24];
      prv_b <= (col == '0) ? 8'h00 : cur_b[31:24];
      prv_c <= (col == '0) ? 8'h00 : cur_c[31:24];
      cur_a <= row_above;
      cur_b <= row_cur;
      cur_c <= row_below;
      cur_col <= col;
      cur_row <= row;
    end
  end

  // Right neighbour of the held word; the flush beat has none (that pixel is border anyway).
  assign nxt_a = (state == FLUSH) ? 8'h00 : row_above[7:0];
  assign nxt_b = (state == FLUSH) ? 8'h00 : row_cur[7:0];
  assign nxt_c = (state == FLUSH) ? 8'h00 : row_below[7:0];

  always_comb begin
    keep_w = 4'b1111;
    if (cur_col == '0)      keep_w[0] = 1'b0;
    if (cur_col == COL_LAST) keep_w[3] = 1'b0;
    if (cur_row == '0 || cur_row == ROW_LAST) keep_w = 4'b0000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0; win_a <= '0; win_b <= '0; win_c <= '0;
      keep1 <= '0; eol1 <= 1'b0; eof1 <= 1'b0;
    end else if (frame_start) begin
      v1 <= 1'b0;
    end else if (en) begin
      v1 <= emit;
      if (emit) begin
        win_a <= {nxt_a, cur_a, prv_a};
        win_b <= {nxt_b, cur_b, prv_b};
        win_c <= {nxt_c, cur_c, prv_c};
        keep1 <= keep_w;
        eol1  <= (cur_col == COL_LAST);
        eof1  <= (cur_col == COL_LAST) && (cur_row == ROW_LAST);
      end
    end
  end

  // Byte j of a window is pixel 4k-1+j; output pixel i is centred on byte i+1.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      gx_c[i] = (px1(win_a[8*(i+2) +: 8]) + px2(win_b[8*(i+2) +: 8]) + px1(win_c[8*(i+2) +: 8]))
              - (px1(win_a[8*i +: 8])     + px2(win_b[8*i +: 8])     + px1(win_c[8*i +: 8]));
      gy_c[i] = (px1(win_a[8*i +: 8]) + px2(win_a[8*(i+1) +: 8]) + px1(win_a[8*(i+2) +: 8]))
              - (px1(win_c[8*i +: 8]) + px2(win_c[8*(i+1) +: 8]) + px1(win_c[8*(i+2) +: 8]));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2 <= 1'b0; keep2 <= '0; eol2 <= 1'b0; eof2 <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        gx2[i] <= '0;
        gy2[i] <= '0;
      end
    end else if (frame_start) begin
      v2 <= 1'b0;
    end else if (en) begin
      v2 <= v1; keep2 <= keep1; eol2 <= eol1; eof2 <= eof1;
      for (int i = 0; i < 4; i++) begin
        gx2[i] <= gx_c[i];
        gy2[i] <= gy_c[i];
      end
    end
  end

  always_comb begin
    pix_c = '0;
    for (int i = 0; i < 4; i++) begin
      mag_c[i] = {1'b0, abs11(gx2[i])} + {1'b0, abs11(gy2[i])};
      pix_c[8*i +: 8] = !keep2[i] ? 8'h00 : (mag_c[i] > 12'd255) ? 8'hFF : mag_c[i][7:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v3 <= 1'b0; pix3 <= '0; eol3 <= 1'b0; eof3 <= 1'b0;
      out_valid <= 1'b0; out_data <= '0; out_eol <= 1'b0; out_eof <= 1'b0;
    end else if (frame_start) begin
      v3 <= 1'b0;
      out_valid <= 1'b0; out_data <= '0; out_eol <= 1'b0; out_eof <= 1'b0;
    end else if (en) begin
      v3 <= v2; pix3 <= pix_c; eol3 <= eol2; eof3 <= eof2;
      out_valid <= v3; out_data <= pix3; out_eol <= eol3; out_eof <= eof3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     busy <= 1'b0;
    else if (frame_start)                        busy <= 1'b0;
    else if (accept)                             busy <= 1'b1;
    else if (out_valid && out_ready && out_eof)  busy <= 1'b0;
  end
endmodule
